pong_game_core: RTL

Parametrised successor of the single-ball Pong logic block. It owns ball, both paddles and the score, and is driven by player buttons. The block moves all sprites on a prescaled game tick, resolves wall/paddle collisions with a fixed priority, and sequences serve / play / point / game-over through a state machine. It sits between the button debouncers and the sprite renderer / score display in the 25 MHz pixel-clock domain.

---
 rtl/pong_game_core.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_core.sv
`default_nettype none
// ============================================================================
// pong_game_core -- ball, paddles, score and serve/play/point/game-over flow
// for Pong, all advanced on a prescaled game tick.  Rev 1.0
// ============================================================================
module pong_game_core #(
  parameter int H_VIDEO     = 640,
  parameter int V_VIDEO     = 480,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_W    = 12,
  parameter int PADDLE_H    = 96,
  parameter int PADDLE1_X   = 24,
  parameter int PADDLE2_X   = 603,
  parameter int PADDLE_STEP = 2,
  parameter int TICK_DIV    = 125_875,
  parameter int SERVE_TICKS = 100,
  parameter int WIN_SCORE   = 11
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       start,
  output logic [9:0] ball_xpos,
  output logic [9:0] ball_ypos,
  output logic [9:0] paddle1_ypos,
  output logic [9:0] paddle2_ypos,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       point_p1,
  output logic       point_p2,
  output logic       serving,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [10:0]   BALL_X0    = 11'((H_VIDEO - BALL_SIZE) / 2);
  localparam logic [10:0]   BALL_Y0    = 11'((V_VIDEO - BALL_SIZE) / 2);
  localparam logic [10:0]   BALL_XMAX  = 11'(H_VIDEO - BALL_SIZE);
  localparam logic [10:0]   BALL_YMAX  = 11'(V_VIDEO - BALL_SIZE);
  localparam logic [10:0]   PAD_Y0     = 11'((V_VIDEO - PADDLE_H) / 2);
  localparam logic [10:0]   PAD_YMAX   = 11'(V_VIDEO - PADDLE_H);
  localparam logic [10:0]   PAD1_FACE  = 11'(PADDLE1_X + PADDLE_W);
  localparam logic [10:0]   PAD2_FACE  = 11'(PADDLE2_X);
  localparam logic [10:0]   STEP       = 11'(PADDLE_STEP);
  localparam logic [10:0]   BSIZE      = 11'(BALL_SIZE);
  localparam logic [10:0]   PHEIGHT    = 11'(PADDLE_H);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic [10:0]   bx_q, bx_d, by_q, by_d;
  logic [10:0]   p1y_q, p1y_d, p2y_q, p2y_d;
  logic          xdir_q, xdir_d;  // 1 = moving right
  logic          ydir_q, ydir_d;  // 1 = moving down
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          pp1_q, pp1_d, pp2_q, pp2_d;

  logic          w_tick;
  logic [10:0]   w_p1y_mv, w_p2y_mv, w_by_mv;
  logic          w_ydir_mv;
  logic          w_ov1, w_ov2, w_hit1, w_hit2, w_miss_l, w_miss_r;

  function automatic logic [10:0] paddle_next(logic [10:0] y, logic up, logic dn);
    if (up && !dn) return (y > STEP) ? y - STEP : 11'd0;
    if (dn && !up) return (y + STEP < PAD_YMAX) ? y + STEP : PAD_YMAX;
    return y;
  endfunction

  assign w_tick   = (tick_cnt_q == TICK_LAST);
  assign w_p1y_mv = paddle_next(p1y_q, p1_up, p1_down);
  assign w_p2y_mv = paddle_next(p2y_q, p2_up, p2_down);

  // Strict inequalities: a ball merely touching a paddle corner misses it.
  assign w_ov1    = (by_q + BSIZE > p1y_q) && (by_q < p1y_q + PHEIGHT);
  assign w_ov2    = (by_q + BSIZE > p2y_q) && (by_q < p2y_q + PHEIGHT);
  assign w_hit1   = !xdir_q && (bx_q == PAD1_FACE) && w_ov1;
  assign w_hit2   = xdir_q && (bx_q + BSIZE == PAD2_FACE) && w_ov2;
  assign w_miss_l = !xdir_q && (bx_q == 11'd0);
  assign w_miss_r = xdir_q && (bx_q == BALL_XMAX);

  always_comb begin
    w_ydir_mv = ydir_q;
    if (ydir_q && by_q == BALL_YMAX)  w_ydir_mv = 1'b0;
    else if (!ydir_q && by_q == 11'd0) w_ydir_mv = 1'b1;
    w_by_mv = w_ydir_mv ? by_q + 11'd1 : by_q - 11'd1;
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = w_tick ? '0 : tick_cnt_q + 1'b1;
    serve_cnt_d = serve_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    p1y_d       = p1y_q;
    p2y_d       = p2y_q;
    xdir_d      = xdir_q;
    ydir_d      = ydir_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    pp1_d       = 1'b0;
    pp2_d       = 1'b0;
    case (state_q)
      ST_SERVE: begin
        if (w_tick) begin
          p1y_d = w_p1y_mv;
          p2y_d = w_p2y_mv;
          if (serve_cnt_q == SERVE_LAST) begin
            serve_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (w_tick) begin
          p1y_d = w_p1y_mv;
          p2y_d = w_p2y_mv;
          // Score and pulse land on the scoring tick so both appear during POINT.
          if (w_hit1) begin
            xdir_d = 1'b1;
            bx_d   = bx_q + 11'd1;
            by_d   = w_by_mv;
            ydir_d = w_ydir_mv;
          end else if (w_hit2) begin
            xdir_d = 1'b0;
            bx_d   = bx_q - 11'd1;
            by_d   = w_by_mv;
            ydir_d = w_ydir_mv;
          end else if (w_miss_l) begin
            s2_d    = s2_q + 4'd1;
            pp2_d   = 1'b1;
            xdir_d  = 1'b0;
            ydir_d  = ~ydir_q;
            state_d = ST_POINT;
          end else if (w_miss_r) begin
            s1_d    = s1_q + 4'd1;
            pp1_d   = 1'b1;
            xdir_d  = 1'b1;
            ydir_d  = ~ydir_q;
            state_d = ST_POINT;
          end else begin
            bx_d   = xdir_q ? bx_q + 11'd1 : bx_q - 11'd1;
            by_d   = w_by_mv;
            ydir_d = w_ydir_mv;
          end
        end
      end
      ST_POINT: begin
        if (s1_q == WIN || s2_q == WIN) begin
          state_d = ST_OVER;
        end else begin
          state_d = ST_SERVE;
          bx_d    = BALL_X0;
          by_d    = BALL_Y0;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_SERVE;
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          p1y_d   = PAD_Y0;
          p2y_d   = PAD_Y0;
          bx_d    = BALL_X0;
          by_d    = BALL_Y0;
        end
      end
      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      p1y_q       <= PAD_Y0;
      p2y_q       <= PAD_Y0;
      xdir_q      <= 1'b0;
      ydir_q      <= 1'b0;
      s1_q        <= 4'd0;
      s2_q        <= 4'd0;
      pp1_q       <= 1'b0;
      pp2_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      p1y_q       <= p1y_d;
      p2y_q       <= p2y_d;
      xdir_q      <= xdir_d;
      ydir_q      <= ydir_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      pp1_q       <= pp1_d;
      pp2_q       <= pp2_d;
    end
  end

  assign ball_xpos    = bx_q[9:0];
  assign ball_ypos    = by_q[9:0];
  assign paddle1_ypos = p1y_q[9:0];
  assign paddle2_ypos = p2y_q[9:0];
  assign score1       = s1_q;
  assign score2       = s2_q;
  assign point_p1     = pp1_q;
  assign point_p2     = pp2_q;
  assign serving      = (state_q == ST_SERVE);
  assign game_over    = (state_q == ST_OVER);

endmodule
`default_nettype wire
